// File: rtl/jtframe_romarb_pkg.sv
// Shared types and constants for the N-slot SDRAM ROM arbiter.
// Watchdog limit applies only when JTFRAME_ROMARB_TIMEOUT_EN is defined.
package jtframe_romarb_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  localparam int SDRAM_AW = 22;
  localparam logic [7:0] TIMEOUT_MAX = 8'd255;
endpackage

// File: rtl/jtframe_romarb_rr.sv
// Combinational round-robin picker: first set req bit
// searching upward from ptr+1 with wrap-around.
module jtframe_romarb_rr
  import jtframe_romarb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int PW    = $clog2(SLOTS)
) (
  input  logic [SLOTS-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    gnt,
  output logic             any
);
  int j;

  always_comb begin
    gnt = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 1; i <= SLOTS; i++) begin
      j = (int'(ptr) + i) % SLOTS;
      if (!any && req[j]) begin
        any = 1'b1;
        gnt = PW'(j);
      end
    end
  end
endmodule

// File: rtl/jtframe_romarb.sv
// N-slot ROM arbiter with one-word cache per slot and primed gate.
// Optional watchdog abort: define JTFRAME_ROMARB_TIMEOUT_EN.
module jtframe_romarb
  import jtframe_romarb_pkg::*;
#(
  parameter int                  SLOTS      = 4,
  parameter int                  SAW        = 18,
  parameter logic [SLOTS*22-1:0] OFFSET     = '0,
  parameter logic [SLOTS-1:0]    PRIME_MASK = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SLOTS-1:0]      slot_cs,
  input  logic [SLOTS*SAW-1:0]  slot_addr,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [SLOTS*16-1:0]   slot_dout,
  output logic                  primed,
  input  logic                  downloading,
  output logic                  sdram_req,
  output logic [SDRAM_AW-1:0]   sdram_addr,
  input  logic                  sdram_ack,
  input  logic                  data_rdy,
  input  logic [15:0]           data_read
`ifdef JTFRAME_ROMARB_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);
  localparam int PW = $clog2(SLOTS);

  state_t           st;
  logic [SAW-1:0]   tag  [SLOTS];
  logic [15:0]      data [SLOTS];
  logic [SLOTS-1:0] valid;
  logic [SLOTS-1:0] fill_seen;
  logic [SLOTS-1:0] pend;
  logic [SLOTS-1:0] miss;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gnt;
  logic [PW-1:0]    pick;
  logic             pick_any;
  logic [SAW-1:0]   lat_addr;
  logic [SAW-1:0]   pick_addr;
`ifdef JTFRAME_ROMARB_TIMEOUT_EN
  logic [7:0]       wdog;
`endif

  always_comb begin
    slot_ok = '0;
    for (int i = 0; i < SLOTS; i++)
      slot_ok[i] = slot_cs[i] & valid[i] &
                   (tag[i] == slot_addr[i*SAW +: SAW]);
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_dout
    assign slot_dout[g*16 +: 16] = data[g];
  end

  assign miss      = slot_cs & ~slot_ok;
  assign primed    = &(fill_seen | ~PRIME_MASK);
  assign pick_addr = slot_addr[pick*SAW +: SAW];

  jtframe_romarb_rr #(
    .SLOTS (SLOTS),
    .PW    (PW)
  ) u_rr (
    .req   (pend),
    .ptr   (ptr),
    .gnt   (pick),
    .any   (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      ptr        <= PW'(SLOTS-1);
      gnt        <= '0;
      lat_addr   <= '0;
      pend       <= '0;
      valid      <= '0;
      fill_seen  <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
`ifdef JTFRAME_ROMARB_TIMEOUT_EN
      wdog       <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      pend <= miss;
`ifdef JTFRAME_ROMARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      if (downloading) begin
        valid     <= '0;
        fill_seen <= '0;
      end
      unique case (st)
        IDLE: begin
          if (!downloading && pick_any) begin
            gnt        <= pick;
            lat_addr   <= pick_addr;
            sdram_addr <= OFFSET[pick*22 +: 22] +
                          SDRAM_AW'(pick_addr);
            sdram_req  <= 1'b1;
            st         <= WAIT_ACK;
`ifdef JTFRAME_ROMARB_TIMEOUT_EN
            wdog       <= 8'd1;
`endif
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            st        <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (data_rdy) begin
            st        <= IDLE;
            ptr       <= gnt;
            // stale miss of the filled slot must not regrant it
            pend[gnt] <= 1'b0;
            if (!downloading) begin
              tag[gnt]       <= lat_addr;
              data[gnt]      <= data_read;
              valid[gnt]     <= 1'b1;
              fill_seen[gnt] <= 1'b1;
            end
          end
        end
        default: st <= IDLE;
      endcase
`ifdef JTFRAME_ROMARB_TIMEOUT_EN
      if (st != IDLE) begin
        if (wdog == TIMEOUT_MAX) begin
          st        <= IDLE;
          sdram_req <= 1'b0;
          ptr       <= gnt;
          timeout   <= 1'b1;
        end else begin
          wdog <= wdog + 8'd1;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_jtframe_romarb.sv
// Directed bench for jtframe_romarb, 4 slots, offsets and prime mask.
// Watchdog scenario runs when JTFRAME_ROMARB_TIMEOUT_EN is defined.
module tb_jtframe_romarb;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  slot_cs;
  logic [71:0] slot_addr;
  logic [3:0]  slot_ok;
  logic [63:0] slot_dout;
  logic        primed;
  logic        downloading;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [15:0] data_read;
`ifdef JTFRAME_ROMARB_TIMEOUT_EN
  logic        timeout;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jtframe_romarb #(
    .SLOTS      (4),
    .SAW        (18),
    .OFFSET     ({22'd0, 22'd0, 22'h14000, 22'd0}),
    .PRIME_MASK (4'b0111)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .slot_cs     (slot_cs),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .primed      (primed),
    .downloading (downloading),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read)
`ifdef JTFRAME_ROMARB_TIMEOUT_EN
    ,
    .timeout     (timeout)
`endif
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_addr(input int i, input logic [17:0] a);
    slot_addr[i*18 +: 18] = a;
  endtask

  function automatic logic [15:0] dout(input int i);
    return slot_dout[i*16 +: 16];
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    slot_cs = '0;
    slot_addr = '0;
    downloading = 1'b0;
    sdram_ack = 1'b0;
    data_rdy = 1'b0;
    data_read = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_req(output logic [21:0] a, output bit to);
    to = 1'b1;
    a = '0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (sdram_req) begin
        to = 1'b0;
        a = sdram_addr;
        break;
      end
    end
  endtask

  task automatic do_ack;
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
  endtask

  task automatic do_data(input logic [15:0] d);
    data_rdy = 1'b1;
    data_read = d;
    tick();
    data_rdy = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp += 5;
    if (slot_ok !== 4'b0) begin
      n_err++; $display("FAIL reset_ok got %h want 0", slot_ok);
    end
    if (slot_dout !== 64'b0) begin
      n_err++; $display("FAIL reset_dout got %h want 0", slot_dout);
    end
    if (primed !== 1'b0) begin
      n_err++; $display("FAIL reset_primed got %b want 0", primed);
    end
    if (sdram_req !== 1'b0) begin
      n_err++; $display("FAIL reset_req got %b want 0", sdram_req);
    end
    if (sdram_addr !== 22'd0) begin
      n_err++; $display("FAIL reset_addr got %h want 0", sdram_addr);
    end
  endtask

  task automatic test_basic_hit;
    logic [21:0] a;
    bit to;
    int reqs;
    do_reset();
    slot_cs = 4'b0001;
    set_addr(0, 18'h00010);
    wait_req(a, to);
    do_ack();
    do_data(16'hBEEF);
    n_cmp++;
    if (to || a !== 22'h000010) begin
      n_err++; $display("FAIL basic_addr got %h to=%0b want 000010", a, to);
    end
    n_cmp++;
    if (slot_ok[0] !== 1'b1 || dout(0) !== 16'hBEEF) begin
      n_err++;
      $display("FAIL basic_hit got ok=%b d=%h want 1 BEEF", slot_ok[0], dout(0));
    end
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sdram_req) reqs++;
    end
    n_cmp++;
    if (reqs != 0 || slot_ok[0] !== 1'b1) begin
      n_err++; $display("FAIL basic_reread got reqs=%0d ok=%b want 0 1", reqs, slot_ok[0]);
    end
  endtask

  task automatic test_round_robin;
    logic [21:0] exp [5];
    logic [21:0] a;
    bit to;
    exp[0] = 22'h000100;
    exp[1] = 22'h014101;
    exp[2] = 22'h000102;
    exp[3] = 22'h000103;
    exp[4] = 22'h000200;
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, 18'(18'h100 + i));
    slot_cs = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_req(a, to);
      do_ack();
      do_data(16'(16'hA000 + k));
      if (k == 0) set_addr(0, 18'h200);
      n_cmp++;
      if (to || a !== exp[k]) begin
        n_err++;
        $display("FAIL rr_grant%0d got %h to=%0b want %h", k, a, to, exp[k]);
      end
    end
    n_cmp++;
    if (slot_ok !== 4'b1111) begin
      n_err++; $display("FAIL rr_all_ok got %b want 1111", slot_ok);
    end
    n_cmp++;
    if (dout(0) !== 16'hA004 || dout(3) !== 16'hA003) begin
      n_err++;
      $display("FAIL rr_dout got %h %h want A004 A003", dout(0), dout(3));
    end
  endtask

  task automatic test_offset;
    logic [21:0] a;
    bit to;
    do_reset();
    slot_cs = 4'b0010;
    set_addr(1, 18'h07FFF);
    wait_req(a, to);
    do_ack();
    do_data(16'h1111);
    n_cmp++;
    if (to || a !== 22'h01BFFF) begin
      n_err++; $display("FAIL offset_addr got %h to=%0b want 01BFFF", a, to);
    end
    n_cmp++;
    if (slot_ok !== 4'b0010 || dout(1) !== 16'h1111) begin
      n_err++;
      $display("FAIL offset_hit got ok=%b d=%h want 0010 1111", slot_ok, dout(1));
    end
  endtask

  task automatic test_abandon;
    logic [21:0] a;
    bit to;
    do_reset();
    slot_cs = 4'b0100;
    set_addr(2, 18'h00300);
    wait_req(a, to);
    do_ack();
    set_addr(2, 18'h00301);
    tick();
    do_data(16'h1234);
    n_cmp++;
    if (to || a !== 22'h000300) begin
      n_err++; $display("FAIL abandon_first got %h to=%0b want 000300", a, to);
    end
    n_cmp++;
    if (slot_ok[2] !== 1'b0 || dout(2) !== 16'h1234) begin
      n_err++;
      $display("FAIL abandon_fill got ok=%b d=%h want 0 1234", slot_ok[2], dout(2));
    end
    wait_req(a, to);
    do_ack();
    do_data(16'h5678);
    n_cmp++;
    if (to || a !== 22'h000301) begin
      n_err++; $display("FAIL abandon_rereq got %h to=%0b want 000301", a, to);
    end
    n_cmp++;
    if (slot_ok[2] !== 1'b1 || dout(2) !== 16'h5678) begin
      n_err++;
      $display("FAIL abandon_hit got ok=%b d=%h want 1 5678", slot_ok[2], dout(2));
    end
  endtask

  task automatic test_primed;
    logic [21:0] a;
    bit to;
    int reqs;
    do_reset();
    set_addr(0, 18'h10);
    set_addr(1, 18'h20);
    set_addr(2, 18'h30);
    set_addr(3, 18'h40);
    slot_cs = 4'b0001;
    wait_req(a, to); do_ack(); do_data(16'h0001);
    slot_cs = 4'b0011;
    wait_req(a, to); do_ack(); do_data(16'h0002);
    n_cmp++;
    if (to || primed !== 1'b0) begin
      n_err++; $display("FAIL primed_early got %b to=%0b want 0", primed, to);
    end
    slot_cs = 4'b0111;
    wait_req(a, to);
    do_ack();
    data_rdy = 1'b1;
    data_read = 16'h0003;
    n_cmp++;
    if (primed !== 1'b0) begin
      n_err++; $display("FAIL primed_fillcyc got %b want 0", primed);
    end
    tick();
    data_rdy = 1'b0;
    n_cmp++;
    if (to || primed !== 1'b1 || slot_ok !== 4'b0111) begin
      n_err++;
      $display("FAIL primed_rise got p=%b ok=%b want 1 0111", primed, slot_ok);
    end
    downloading = 1'b1;
    tick();
    n_cmp++;
    if (primed !== 1'b0 || slot_ok !== 4'b0000) begin
      n_err++;
      $display("FAIL dl_clear got p=%b ok=%b want 0 0000", primed, slot_ok);
    end
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sdram_req) reqs++;
    end
    n_cmp++;
    if (reqs != 0) begin
      n_err++; $display("FAIL dl_nogrant got reqs=%0d want 0", reqs);
    end
    downloading = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [21:0] a;
    bit to;
    do_reset();
    slot_cs = 4'b0001;
    set_addr(0, 18'h40);
    wait_req(a, to);
    do_ack();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (to || sdram_req !== 1'b0) begin
      n_err++; $display("FAIL rstmid_req got %b to=%0b want 0", sdram_req, to);
    end
    rst = 1'b0;
    data_rdy = 1'b1;
    data_read = 16'hDEAD;
    tick();
    data_rdy = 1'b0;
    n_cmp++;
    if (slot_ok[0] !== 1'b0 || dout(0) !== 16'h0000) begin
      n_err++;
      $display("FAIL rstmid_late got ok=%b d=%h want 0 0000", slot_ok[0], dout(0));
    end
  endtask

`ifdef JTFRAME_ROMARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [21:0] a;
    bit to;
    int n;
    bit seen;
    do_reset();
    set_addr(0, 18'h50);
    set_addr(1, 18'h60);
    slot_cs = 4'b0011;
    wait_req(a, to);
    sdram_ack = 1'b1;
    n = 0;
    seen = 1'b0;
    for (int i = 1; i < 400; i++) begin
      tick();
      sdram_ack = 1'b0;
      if (timeout) begin
        n = i;
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (to || !seen || n != 255) begin
      n_err++; $display("FAIL timeout_cycle got %0d seen=%0b want 255", n, seen);
    end
    n_cmp++;
    if (sdram_req !== 1'b0) begin
      n_err++; $display("FAIL timeout_req got %b want 0", sdram_req);
    end
    tick();
    n_cmp++;
    if (timeout !== 1'b0) begin
      n_err++; $display("FAIL timeout_pulse got %b want 0", timeout);
    end
    wait_req(a, to);
    n_cmp++;
    if (to || a !== 22'h014060) begin
      n_err++; $display("FAIL timeout_next got %h to=%0b want 014060", a, to);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_hit();
    test_round_robin();
    test_offset();
    test_abandon();
    test_primed();
    test_reset_mid();
`ifdef JTFRAME_ROMARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
